// File: rtl/mips_pkg.sv
// Shared pipeline definitions: memory-stage FSM states and the cache/memory
// mux select encodings used by the MEM-stage controller.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } mem_state_t;

  // cache_input_type encodings
  localparam logic CACHE_SRC_PIPE = 1'b0;
  localparam logic CACHE_SRC_MEM  = 1'b1;

  // memory_address_type encodings
  localparam logic ADDR_REQ    = 1'b0;
  localparam logic ADDR_VICTIM = 1'b1;

endpackage

// File: rtl/mem_stage_controller_if.sv
// MEM-stage bundle: EX/MEM control fields and cache status in, cache/memory
// control and pipeline lock out. master = pipeline/cache side, slave = controller.
interface mem_stage_if;

  logic mem_read_mem;
  logic mem_write_mem;
  logic is_nop_mem;
  logic halted_controller_mem;
  logic cache_hit;
  logic cache_dirty;

  logic lock;
  logic we_cache;
  logic cache_input_type;
  logic set_dirty;
  logic set_valid;
  logic memory_address_type;
  logic we_memory;
  logic busy;

  modport master (
    output mem_read_mem, mem_write_mem, is_nop_mem, halted_controller_mem,
           cache_hit, cache_dirty,
    input  lock, we_cache, cache_input_type, set_dirty, set_valid,
           memory_address_type, we_memory, busy
  );

  modport slave (
    input  mem_read_mem, mem_write_mem, is_nop_mem, halted_controller_mem,
           cache_hit, cache_dirty,
    output lock, we_cache, cache_input_type, set_dirty, set_valid,
           memory_address_type, we_memory, busy
  );

endinterface

// File: rtl/mem_stage_controller_latency_counter.sv
// Down-counter timing one main-memory transfer: reloads to MEM_LATENCY-1,
// decrements while enabled, and flags done at zero.
module latency_counter #(
  parameter int MEM_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int              CW     = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0]   RELOAD = CW'(MEM_LATENCY - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)      cnt <= '0;
    else if (load)   cnt <= RELOAD;
    else if (dec)    cnt <= cnt - CW'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mem_stage_controller.sv
// MEM-stage cache controller: same-cycle hits, write-back/fill on miss with
// pipeline lock. Optional MEM_STAGE_STATS_EN adds miss/stall counters.
module mem_stage_controller
  import mips_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  mem_stage_if.slave    bus
`ifdef MEM_STAGE_STATS_EN
  ,
  output logic [31:0]   miss_count,
  output logic [31:0]   stall_cycles
`endif
);

  mem_state_t state, state_next;

  logic access;
  logic cnt_load, cnt_dec, cnt_done;
  logic lock, we_cache, cache_input_type, set_dirty, set_valid;
  logic memory_address_type, we_memory;

  // Gated by rst_b so that asserting reset mid-miss drops lock and blocks any
  // write in the same instant, even though the frozen inputs still show a miss.
  assign access = rst_b
                & (bus.mem_read_mem | bus.mem_write_mem)
                & ~bus.is_nop_mem
                & ~bus.halted_controller_mem;

  latency_counter #(.MEM_LATENCY(MEM_LATENCY)) u_latency_counter (
    .clk   (clk),
    .rst_b (rst_b),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .done  (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output is given a default before the case statement; any path
  // that skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_next          = state;
    cnt_load            = 1'b0;
    cnt_dec             = 1'b0;
    lock                = 1'b0;
    we_cache            = 1'b0;
    cache_input_type    = CACHE_SRC_PIPE;
    set_dirty           = 1'b0;
    set_valid           = 1'b0;
    memory_address_type = ADDR_REQ;
    we_memory           = 1'b0;

    case (state)
      IDLE: begin
        if (access) begin
          if (bus.cache_hit) begin
            if (bus.mem_write_mem) begin
              we_cache  = 1'b1;
              set_dirty = 1'b1;
              set_valid = 1'b1;
            end
          end else begin
            lock       = 1'b1;
            cnt_load   = 1'b1;
            state_next = bus.cache_dirty ? WRITEBACK : FILL;
          end
        end
      end

      WRITEBACK: begin
        lock                = 1'b1;
        memory_address_type = ADDR_VICTIM;
        if (cnt_done) begin
          we_memory  = 1'b1;
          cnt_load   = 1'b1;
          state_next = FILL;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      FILL: begin
        lock = 1'b1;
        if (cnt_done) begin
          we_cache         = 1'b1;
          cache_input_type = CACHE_SRC_MEM;
          set_valid        = 1'b1;
          state_next       = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.lock                = lock;
  assign bus.we_cache            = we_cache;
  assign bus.cache_input_type    = cache_input_type;
  assign bus.set_dirty           = set_dirty;
  assign bus.set_valid           = set_valid;
  assign bus.memory_address_type = memory_address_type;
  assign bus.we_memory           = we_memory;
  assign bus.busy                = (state != IDLE);

`ifdef MEM_STAGE_STATS_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      miss_count   <= '0;
      stall_cycles <= '0;
    end else begin
      if (state == IDLE && state_next != IDLE && miss_count != '1)
        miss_count <= miss_count + 32'd1;
      if (lock && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
